// File: rtl/load_store_unit.sv
// Load/store engine: splits RV32 byte/half/word accesses into narrow bus beats,
// reassembles and extends load data, and flags misalignment and bus timeouts.
module load_store_unit #(
  parameter int unsigned BUS_ADDRESS_WIDTH = 8,
  parameter int unsigned BUS_DATA_WIDTH    = 8,
  parameter int unsigned TIMEOUT_CYCLES    = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           request,
  input  logic                           write,
  input  logic [1:0]                     size,
  input  logic                           unsigned_load,
  input  logic [31:0]                    address,
  input  logic [31:0]                    store_data,
  output logic                           busy,
  output logic                           done,
  output logic [31:0]                    load_data,
  output logic                           misaligned,
  output logic                           bus_error,
  output logic [BUS_ADDRESS_WIDTH-1:0]   bus_address,
  output logic                           bus_valid,
  output logic                           bus_write_enable,
  output logic [BUS_DATA_WIDTH/8-1:0]    bus_byte_enable,
  output logic [BUS_DATA_WIDTH-1:0]      bus_write_data,
  input  logic [BUS_DATA_WIDTH-1:0]      bus_read_data,
  input  logic                           bus_ready
);

  localparam int unsigned LANES = BUS_DATA_WIDTH / 8;
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 2);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ACCESS   = 2'd1;
  localparam logic [1:0] S_FAULT    = 2'd2;
  localparam logic [1:0] S_COMPLETE = 2'd3;

  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      2'b00:   nbytes = 1;
      2'b01:   nbytes = 2;
      default: nbytes = 4;
    endcase
  endfunction

  // Access-relative byte index carried by a lane of a given beat.
  function automatic int lane_rel(input logic [2:0] beat, input int lane, input logic [31:0] addr);
    lane_rel = int'(beat) * int'(LANES) + lane - (int'(addr[1:0]) % int'(LANES));
  endfunction

  function automatic logic lane_hit(input logic [2:0] beat, input int lane,
                                    input logic [31:0] addr, input logic [1:0] sz);
    int rel;
    rel = lane_rel(beat, lane, addr);
    lane_hit = (rel >= 0) && (rel < nbytes(sz));
  endfunction

  function automatic int nbeats(input logic [1:0] sz);
    nbeats = (nbytes(sz) > int'(LANES)) ? nbytes(sz) / int'(LANES) : 1;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] sz,
                                         input logic uns);
    case (sz)
      2'b00:   extend = uns ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   extend = uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  logic [1:0]                    state_q, state_d;
  logic                          wr_q, wr_d, uns_q, uns_d;
  logic [1:0]                    size_q, size_d;
  logic [31:0]                   addr_q, addr_d, sdata_q, sdata_d, asm_q, asm_d;
  logic [2:0]                    beat_q, beat_d;
  logic [TW-1:0]                 tmo_q, tmo_d;
  logic                          busy_q, busy_d, done_q, done_d;
  logic                          misaligned_q, misaligned_d, bus_error_q, bus_error_d;
  logic [31:0]                   load_data_q, load_data_d;
  logic [BUS_ADDRESS_WIDTH-1:0]  bus_address_q, bus_address_d;
  logic                          bus_valid_q, bus_valid_d, bus_we_q, bus_we_d;
  logic [BUS_DATA_WIDTH/8-1:0]   bus_be_q, bus_be_d;
  logic [BUS_DATA_WIDTH-1:0]     bus_wd_q, bus_wd_d;

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    uns_d        = uns_q;
    size_d       = size_q;
    addr_d       = addr_q;
    sdata_d      = sdata_q;
    asm_d        = asm_q;
    beat_d       = beat_q;
    tmo_d        = tmo_q;
    load_data_d  = load_data_q;
    done_d       = 1'b0;
    misaligned_d = 1'b0;
    bus_error_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (request) begin
          if ((address[1:0] & 2'(nbytes(size) - 1)) != 2'b00) begin
            state_d      = S_FAULT;
            done_d       = 1'b1;
            misaligned_d = 1'b1;
          end else begin
            state_d = S_ACCESS;
            wr_d    = write;
            uns_d   = unsigned_load;
            size_d  = size;
            addr_d  = address;
            sdata_d = store_data;
            asm_d   = '0;
            beat_d  = '0;
            tmo_d   = '0;
          end
        end
      end
      S_ACCESS: begin
        if (bus_ready) begin
          tmo_d = '0;
          if (!wr_q) begin
            for (int i = 0; i < int'(LANES); i++) begin
              if (lane_hit(beat_q, i, addr_q, size_q))
                asm_d[8*lane_rel(beat_q, i, addr_q) +: 8] = bus_read_data[8*i +: 8];
            end
          end
          if (int'(beat_q) == nbeats(size_q) - 1) begin
            state_d = S_COMPLETE;
            done_d  = 1'b1;
            if (!wr_q) load_data_d = extend(asm_d, size_q, uns_q);
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          if (32'(tmo_q) + 32'd1 == TIMEOUT_CYCLES) begin
            state_d     = S_COMPLETE;
            done_d      = 1'b1;
            bus_error_d = 1'b1;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d        = (state_d != S_IDLE);
    bus_valid_d   = (state_d == S_ACCESS);
    bus_we_d      = bus_valid_d & wr_d;
    bus_address_d = '0;
    bus_be_d      = '0;
    bus_wd_d      = '0;
    if (bus_valid_d) begin
      bus_address_d = BUS_ADDRESS_WIDTH'((addr_d & ~32'(LANES - 1)) + 32'(beat_d) * 32'(LANES));
      for (int i = 0; i < int'(LANES); i++) begin
        if (lane_hit(beat_d, i, addr_d, size_d)) begin
          bus_be_d[i] = 1'b1;
          if (wr_d) bus_wd_d[8*i +: 8] = sdata_d[8*lane_rel(beat_d, i, addr_d) +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wr_q          <= 1'b0;
      uns_q         <= 1'b0;
      size_q        <= 2'b00;
      addr_q        <= '0;
      sdata_q       <= '0;
      asm_q         <= '0;
      beat_q        <= '0;
      tmo_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      misaligned_q  <= 1'b0;
      bus_error_q   <= 1'b0;
      load_data_q   <= '0;
      bus_address_q <= '0;
      bus_valid_q   <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_be_q      <= '0;
      bus_wd_q      <= '0;
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_d;
      uns_q         <= uns_d;
      size_q        <= size_d;
      addr_q        <= addr_d;
      sdata_q       <= sdata_d;
      asm_q         <= asm_d;
      beat_q        <= beat_d;
      tmo_q         <= tmo_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      misaligned_q  <= misaligned_d;
      bus_error_q   <= bus_error_d;
      load_data_q   <= load_data_d;
      bus_address_q <= bus_address_d;
      bus_valid_q   <= bus_valid_d;
      bus_we_q      <= bus_we_d;
      bus_be_q      <= bus_be_d;
      bus_wd_q      <= bus_wd_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign load_data        = load_data_q;
  assign misaligned       = misaligned_q;
  assign bus_error        = bus_error_q;
  assign bus_address      = bus_address_q;
  assign bus_valid        = bus_valid_q;
  assign bus_write_enable = bus_we_q;
  assign bus_byte_enable  = bus_be_q;
  assign bus_write_data   = bus_wd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: an 8-bit-bus instance with a short timeout and a 32-bit-bus
// instance, each compared beat-by-beat and completion-by-completion.
module tb_load_store_unit;

  localparam int TB_TIMEOUT = 4;

  typedef struct { logic [7:0] addr; logic we; logic [3:0] be; logic [31:0] wd; } beat_t;
  typedef struct { logic mis; logic err; logic [31:0] ld; } comp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req8 = 1'b0, req32 = 1'b0, wr = 1'b0, uns = 1'b0;
  logic [1:0]  sz = 2'b00;
  logic [31:0] addr = '0, sdata = '0;
  logic        rdy8 = 1'b1, rdy8_fix = 1'b1, stall_mode = 1'b0;
  logic        rdy32;
  int          stall_cnt = 0;
  logic [7:0]  mem [256];

  logic        busy8, done8, mis8, err8, v8, we8;
  logic [31:0] ld8;
  logic [7:0]  ba8, wd8, rd8;
  logic [0:0]  be8;
  logic        busy32, done32, mis32, err32, v32, we32;
  logic [31:0] ld32, wd32, rd32;
  logic [7:0]  ba32;
  logic [3:0]  be32;

  beat_t q8[$], q32[$];
  comp_t c8[$], c32[$];
  logic [31:0] last8 = '0, last32 = '0;
  int n_vec = 0, n_err = 0;

  assign rdy32 = 1'b1;
  assign rd8   = mem[ba8];
  assign rd32  = {mem[ba32 + 8'd3], mem[ba32 + 8'd2], mem[ba32 + 8'd1], mem[ba32]};

  load_store_unit #(.BUS_ADDRESS_WIDTH(8), .BUS_DATA_WIDTH(8), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut8 (
    .clk(clk), .rst_n(rst_n), .request(req8), .write(wr), .size(sz), .unsigned_load(uns),
    .address(addr), .store_data(sdata), .busy(busy8), .done(done8), .load_data(ld8),
    .misaligned(mis8), .bus_error(err8), .bus_address(ba8), .bus_valid(v8),
    .bus_write_enable(we8), .bus_byte_enable(be8), .bus_write_data(wd8),
    .bus_read_data(rd8), .bus_ready(rdy8));

  load_store_unit #(.BUS_ADDRESS_WIDTH(8), .BUS_DATA_WIDTH(32), .TIMEOUT_CYCLES(0)) dut32 (
    .clk(clk), .rst_n(rst_n), .request(req32), .write(wr), .size(sz), .unsigned_load(uns),
    .address(addr), .store_data(sdata), .busy(busy32), .done(done32), .load_data(ld32),
    .misaligned(mis32), .bus_error(err32), .bus_address(ba32), .bus_valid(v32),
    .bus_write_enable(we32), .bus_byte_enable(be32), .bus_write_data(wd32),
    .bus_read_data(rd32), .bus_ready(rdy32));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Ready for the 8-bit bus: fixed level, or a pattern with at most two low cycles in a row.
  always @(posedge clk) begin
    #1;
    stall_cnt = stall_cnt + 1;
    rdy8 = stall_mode ? (stall_cnt % 3 == 0) : rdy8_fix;
  end

  // Expected beats and completion for one access, built byte by byte.
  task automatic model(input bit sel, input bit w, input logic [1:0] s, input bit u,
                       input logic [31:0] a, input logic [31:0] d, output int lat, output int nv);
    int n, l, nb, lane;
    logic [31:0] base, raw;
    beat_t b;
    comp_t c;
    n  = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    l  = sel ? 4 : 1;
    nb = (n > l) ? n / l : 1;
    c.mis = 1'b0; c.err = 1'b0; c.ld = sel ? last32 : last8;
    if (a % n != 0) begin
      c.mis = 1'b1; lat = 1; nv = 0;
    end else if (!sel && !rdy8_fix && !stall_mode) begin
      c.err = 1'b1; lat = TB_TIMEOUT + 1; nv = TB_TIMEOUT;
    end else begin
      base = a & ~32'(l - 1);
      for (int k = 0; k < nb; k++) begin
        b.addr = 8'(base + 32'(k * l)); b.we = w; b.be = '0; b.wd = '0;
        for (int j = 0; j < n; j++) begin
          if (((a + 32'(j)) & ~32'(l - 1)) == base + 32'(k * l)) begin
            lane = int'((a + 32'(j)) % 32'(l));
            b.be[lane] = 1'b1;
            if (w) b.wd[8*lane +: 8] = d[8*j +: 8];
          end
        end
        if (sel) q32.push_back(b); else q8.push_back(b);
      end
      if (!w) begin
        raw = '0;
        for (int j = 0; j < n; j++) raw[8*j +: 8] = mem[8'(a + 32'(j))];
        case (n)
          1:       c.ld = u ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
          2:       c.ld = u ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
          default: c.ld = raw;
        endcase
        if (sel) last32 = c.ld; else last8 = c.ld;
      end
      lat = nb + 1; nv = nb;
    end
    if (sel) c32.push_back(c); else c8.push_back(c);
  endtask

  // Issue one access on the selected instance and time it; called at a falling edge.
  task automatic acc(input bit sel, input bit w, input logic [1:0] s, input bit u,
                     input logic [31:0] a, input logic [31:0] d);
    int lat, nv, cyc, vcnt;
    bit got, busy_seen;
    model(sel, w, s, u, a, d, lat, nv);
    wr = w; sz = s; uns = u; addr = a; sdata = d;
    if (sel) req32 = 1'b1; else req8 = 1'b1;
    @(posedge clk); #1;
    req8 = 1'b0; req32 = 1'b0;
    cyc = 0; vcnt = 0; got = 1'b0; busy_seen = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (sel ? v32 : v8) vcnt++;
      if (sel ? done32 : done8) begin
        got = 1'b1;
        busy_seen = sel ? busy32 : busy8;
      end
    end
    check_eq("done_seen", 32'(got), 32'd1);
    if (!stall_mode) begin
      check_eq("latency", cyc, lat);
      check_eq("valid_cycles", vcnt, nv);
    end
    check_eq("busy_at_done", 32'(busy_seen), 32'd1);
    @(negedge clk);
    check_eq("idle_after_done", 32'(sel ? busy32 : busy8), 32'd0);
  endtask

  // 8-bit instance monitor: beat scoreboard, completion scoreboard, stall stability.
  logic        p_stall8 = 1'b0;
  logic [17:0] p_bus8 = '0;
  always @(negedge clk) begin
    beat_t b;
    comp_t c;
    if (rst_n) begin
      if (p_stall8 && v8) check_eq("stall_hold8", 32'({we8, be8, ba8, wd8}), 32'(p_bus8));
      if (v8 && rdy8) begin
        check_eq("beat8_pending", 32'(q8.size() != 0), 32'd1);
        if (q8.size() != 0) begin
          b = q8.pop_front();
          check_eq("addr8", 32'(ba8), 32'(b.addr));
          check_eq("we8", 32'(we8), 32'(b.we));
          check_eq("be8", 32'(be8), 32'(b.be[0]));
          check_eq("wdata8", 32'(wd8), 32'(b.wd[7:0]));
        end
      end
      if (done8) begin
        check_eq("done8_pending", 32'(c8.size() != 0), 32'd1);
        if (c8.size() != 0) begin
          c = c8.pop_front();
          check_eq("misaligned8", 32'(mis8), 32'(c.mis));
          check_eq("bus_error8", 32'(err8), 32'(c.err));
          check_eq("load_data8", ld8, c.ld);
        end
      end
    end
    p_stall8 <= rst_n && v8 && !rdy8;
    p_bus8   <= {we8, be8, ba8, wd8};
  end

  // 32-bit instance monitor.
  always @(negedge clk) begin
    beat_t b;
    comp_t c;
    if (rst_n) begin
      if (v32 && rdy32) begin
        check_eq("beat32_pending", 32'(q32.size() != 0), 32'd1);
        if (q32.size() != 0) begin
          b = q32.pop_front();
          check_eq("addr32", 32'(ba32), 32'(b.addr));
          check_eq("we32", 32'(we32), 32'(b.we));
          check_eq("be32", 32'(be32), 32'(b.be));
          check_eq("wdata32", wd32, b.wd);
        end
      end
      if (done32) begin
        check_eq("done32_pending", 32'(c32.size() != 0), 32'd1);
        if (c32.size() != 0) begin
          c = c32.pop_front();
          check_eq("misaligned32", 32'(mis32), 32'(c.mis));
          check_eq("bus_error32", 32'(err32), 32'(c.err));
          check_eq("load_data32", ld32, c.ld);
        end
      end
    end
  end

  initial begin
    int lat, nv;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[8'h10] = 8'h78; mem[8'h11] = 8'h56; mem[8'h12] = 8'h34; mem[8'h13] = 8'h12;
    mem[8'h20] = 8'h5A; mem[8'h21] = 8'h80;

    #2;
    check_eq("reset_ctrl8", 32'({busy8, done8, mis8, err8, v8, we8, be8, ba8, wd8}), 32'd0);
    check_eq("reset_ld8", ld8, 32'd0);
    check_eq("reset_ctrl32", 32'({busy32, done32, mis32, err32, v32, we32, be32, ba32}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 8-bit bus, ready held high.
    acc(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    acc(1'b0, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
    acc(1'b0, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
    acc(1'b0, 1'b0, 2'b01, 1'b0, 32'h03, 32'h0);
    acc(1'b0, 1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
    acc(1'b0, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
    acc(1'b0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    acc(1'b0, 1'b1, 2'b00, 1'b0, 32'h07, 32'hAABBCCDD);
    acc(1'b0, 1'b1, 2'b01, 1'b0, 32'h0A, 32'h00001234);
    acc(1'b0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    acc(1'b0, 1'b0, 2'b10, 1'b0, 32'h1FC, 32'h0);

    // 8-bit bus with ready stalls.
    stall_mode = 1'b1;
    acc(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    acc(1'b0, 1'b1, 2'b01, 1'b0, 32'h30, 32'h0000C0DE);
    acc(1'b0, 1'b0, 2'b00, 1'b1, 32'h41, 32'h0);
    stall_mode = 1'b0;

    // Timeout with ready held low; a request raised mid-access must be ignored.
    rdy8_fix = 1'b0;
    fork
      acc(1'b0, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
      begin
        @(negedge clk); @(negedge clk);
        req8 = 1'b1;
        @(negedge clk);
        req8 = 1'b0;
      end
    join
    rdy8_fix = 1'b1;
    @(negedge clk);
    check_eq("stray_request_ignored", 32'(busy8), 32'd0);

    // Reset during the third beat of a word load.
    wr = 1'b0; sz = 2'b10; uns = 1'b0; addr = 32'h10;
    model(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, nv);
    req8 = 1'b1;
    @(posedge clk); #1;
    req8 = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_eq("midreset_ctrl8", 32'({busy8, done8, mis8, err8, v8, we8, be8, ba8, wd8}), 32'd0);
    check_eq("midreset_ld8", ld8, 32'd0);
    @(negedge clk);
    q8.delete(); c8.delete();
    last8 = '0; last32 = '0;
    check_eq("midreset_no_done", 32'(done8), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset_no_done", 32'(done8), 32'd0);
    acc(1'b0, 1'b1, 2'b10, 1'b0, 32'hFC, 32'hCAFEF00D);
    acc(1'b0, 1'b1, 2'b10, 1'b0, 32'hFE, 32'h11223344);

    // 32-bit bus.
    acc(1'b1, 1'b1, 2'b01, 1'b0, 32'h06, 32'h0000BEEF);
    acc(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    acc(1'b1, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
    acc(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    acc(1'b1, 1'b1, 2'b00, 1'b0, 32'h03, 32'hAABBCCDD);
    acc(1'b1, 1'b0, 2'b01, 1'b0, 32'h03, 32'h0);
    acc(1'b1, 1'b0, 2'b00, 1'b1, 32'h22, 32'h0);

    repeat (3) @(negedge clk);
    check_eq("queues_drained", 32'(q8.size() + c8.size() + q32.size() + c32.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
